// File: rtl/m72_pic.sv
// ---------------------------------------------------------------------------
// m72_pic
// Priority interrupt controller for the M72 main CPU. An 8259A-compatible
// subset: single controller, edge-triggered inputs, 8086 vector mode, fixed
// priority with IR0 highest. Sits between the video timing pulses (VBLK on
// IR0, HINT on IR2) and the CPU interrupt request/acknowledge interface.
//
// Ports
//   clock    in   system clock
//   reset_n  in   asynchronous, active-low reset
//   cs       in   chip select; wr is ignored unless cs is high
//   a0       in   register select
//   wr       in   single-cycle write strobe
//   din      in   write data [7:0]
//   dout     out  read data [7:0]; a0=0 gives IRR or ISR (per rsel), a0=1 gives IMR
//   ir       in   interrupt request lines [7:0], synchronous to clock
//   inta     in   single-cycle interrupt-acknowledge strobe
//   int_rq   out  registered interrupt request to the CPU
//   vector   out  registered vector {base[4:0], level[2:0]}
// ---------------------------------------------------------------------------
module m72_pic (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cs,
   input  logic       a0,
   input  logic       wr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic [7:0] ir,
   input  logic       inta,
   output logic       int_rq,
   output logic [7:0] vector
);

   typedef enum logic [1:0] {READY, W_ICW2, W_ICW3, W_ICW4} state_t;

   state_t      state_q, state_d;
   logic [7:0]  irr_q, irr_d;
   logic [7:0]  isr_q, isr_d;
   logic [7:0]  imr_q, imr_d;
   logic [4:0]  base_q, base_d;
   logic        sngl_q, sngl_d;
   logic        ic4_q, ic4_d;
   logic        aeoi_q, aeoi_d;
   logic        rsel_q, rsel_d;
   logic [7:0]  ir_dly_q;
   logic        int_rq_q, int_rq_d;
   logic [7:0]  vector_q, vector_d;

   logic        wr_en;
   logic        icw1;
   logic        commit;
   logic [2:0]  commit_lvl;
   logic [7:0]  rise;
   logic [3:0]  pick;

   // Highest-priority serviceable request: {found, level}. A set ISR bit
   // blocks its own level and every lower-priority level.
   function automatic logic [3:0] pick_level(input logic [7:0] irr,
                                             input logic [7:0] isr,
                                             input logic [7:0] imr);
      logic [3:0] res;
      logic       blocked;
      res     = 4'b0111;
      blocked = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (isr[n])
            blocked = 1'b1;
         if (!blocked && !res[3] && irr[n] && !imr[n])
            res = {1'b1, n[2:0]};
      end
      return res;
   endfunction

   // Clear the highest-priority (lowest-numbered) set bit.
   function automatic logic [7:0] clear_lowest(input logic [7:0] v);
      logic [7:0] res;
      logic       done;
      res  = v;
      done = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (!done && v[n]) begin
            res[n] = 1'b0;
            done   = 1'b1;
         end
      end
      return res;
   endfunction

   assign wr_en      = cs & wr;
   // ICW1 is recognised in every state and restarts initialisation.
   assign icw1       = wr_en & ~a0 & din[4];
   // An acknowledge with no request outstanding is spurious and changes nothing.
   assign commit     = inta & int_rq_q;
   assign commit_lvl = vector_q[2:0];
   assign rise       = ir & ~ir_dly_q;
   assign pick       = pick_level(irr_q, isr_q, imr_q);

   always_comb begin
      state_d  = state_q;
      irr_d    = irr_q;
      isr_d    = isr_q;
      imr_d    = imr_q;
      base_d   = base_q;
      sngl_d   = sngl_q;
      ic4_d    = ic4_q;
      aeoi_d   = aeoi_q;
      rsel_d   = rsel_q;

      if (icw1) begin
         irr_d   = 8'h00;
         isr_d   = 8'h00;
         imr_d   = 8'h00;
         rsel_d  = 1'b0;
         aeoi_d  = 1'b0;
         sngl_d  = din[1];
         ic4_d   = din[0];
         state_d = W_ICW2;
      end else begin
         case (state_q)
            W_ICW2: begin
               if (wr_en && a0) begin
                  base_d = din[7:3];
                  if (!sngl_q)
                     state_d = W_ICW3;
                  else if (ic4_q)
                     state_d = W_ICW4;
                  else
                     state_d = READY;
               end
            end
            W_ICW3: begin
               // Cascade configuration is not supported; the byte is dropped.
               if (wr_en && a0)
                  state_d = ic4_q ? W_ICW4 : READY;
            end
            W_ICW4: begin
               if (wr_en && a0) begin
                  aeoi_d  = din[1];
                  state_d = READY;
               end
            end
            READY: begin
               if (wr_en) begin
                  if (a0) begin
                     imr_d = din;
                  end else if (din[4:3] == 2'b00) begin
                     if (din[7:5] == 3'b001)
                        isr_d = clear_lowest(isr_q);
                     else if (din[7:5] == 3'b011)
                        isr_d[din[2:0]] = 1'b0;
                  end else if (din[4:3] == 2'b01) begin
                     if (din[1])
                        rsel_d = din[0];
                  end
               end
            end
            default: ;
         endcase

         // EOI above works on the pre-acknowledge ISR; the acknowledge then
         // sets its own bit. A fresh edge on the acknowledged line re-arms IRR.
         if (commit) begin
            irr_d[commit_lvl] = 1'b0;
            if (!aeoi_q)
               isr_d[commit_lvl] = 1'b1;
         end
         irr_d = irr_d | rise;
      end

      int_rq_d = (state_q == READY) & pick[3] & ~icw1;
      vector_d = {base_q, pick[2:0]};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= READY;
         irr_q    <= 8'h00;
         isr_q    <= 8'h00;
         imr_q    <= 8'hFF;
         base_q   <= 5'd0;
         sngl_q   <= 1'b0;
         ic4_q    <= 1'b0;
         aeoi_q   <= 1'b0;
         rsel_q   <= 1'b0;
         ir_dly_q <= 8'h00;
         int_rq_q <= 1'b0;
         vector_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         irr_q    <= irr_d;
         isr_q    <= isr_d;
         imr_q    <= imr_d;
         base_q   <= base_d;
         sngl_q   <= sngl_d;
         ic4_q    <= ic4_d;
         aeoi_q   <= aeoi_d;
         rsel_q   <= rsel_d;
         ir_dly_q <= ir;
         int_rq_q <= int_rq_d;
         vector_q <= vector_d;
      end
   end

   assign dout   = a0 ? imr_q : (rsel_q ? isr_q : irr_q);
   assign int_rq = int_rq_q;
   assign vector = vector_q;

endmodule

// File: doc/m72_pic.md
# m72_pic

Priority interrupt controller for the M72 main CPU: a synchronous, 8259A-compatible subset (single, edge-triggered, 8086 mode, fixed priority) sitting between the video timing generator's VBLK/HINT pulses and the zet core's interrupt request/acknowledge interface. It replaces the ad-hoc vblank/hint trigger registers and the stub `pic` register in the top level. The top level muxes `vector` onto the CPU data bus during interrupt-acknowledge cycles and `dout` onto it for INTCS reads.

## Interface
Parameters: none.
- clock  in  1  system clock (CLK_32M domain)
- reset_n  in  1  asynchronous, active-low reset
- cs  in  1  chip select (INTCS decode)
- a0  in  1  register select (cpu_addr[1])
- wr  in  1  single-cycle write strobe; ignored unless cs
- din  in  8  write data (cpu_dout[7:0])
- dout  out  8  read data, combinational from registers
- ir  in  8  interrupt request lines, synchronous to clock; IR0 = VBLK, IR2 = HINT, rest tied 0
- inta  in  1  single-cycle interrupt-acknowledge strobe
- int_rq  out  1  registered interrupt request to CPU
- vector  out  8  registered vector, {base[7:3], level[2:0]}

## Operation
- Registers: IRR[7:0], ISR[7:0], IMR[7:0], base[4:0], sngl, ic4, aeoi, rsel (0=IRR, 1=ISR), ir_d[7:0].
- Init FSM states: READY, W_ICW2, W_ICW3, W_ICW4.
  - Write a0=0, din[4]=1 (ICW1), any state: IMR<=0, ISR<=0, IRR<=0, rsel<=0, aeoi<=0, sngl<=din[1], ic4<=din[0], ->W_ICW2.
  - W_ICW2, write a0=1: base<=din[7:3]; ->W_ICW3 if !sngl, else W_ICW4 if ic4, else READY.
  - W_ICW3, write a0=1: data discarded; ->W_ICW4 if ic4 else READY.
  - W_ICW4, write a0=1: aeoi<=din[1]; ->READY.
- READY writes: a0=1 OCW1: IMR<=din. a0=0,din[4:3]=00 OCW2: din[7:5]=001 non-specific EOI clears highest-priority set ISR bit; 011 specific EOI clears ISR[din[2:0]]; other codes ignored. a0=0,din[4:3]=01 OCW3: if din[1], rsel<=din[0].
- Reads: a0=0 -> rsel ? ISR : IRR; a0=1 -> IMR. Reads have no side effects.
- Edge detect: IRR[n] sets when ir[n]=1 and ir_d[n]=0; ir_d<=ir every cycle.
- Priority fixed, IR0 highest. Candidate = lowest n with IRR[n] & ~IMR[n] and n below the lowest set ISR bit (ISR empty: any n).
- int_rq <= (state==READY) & candidate exists. vector <= {base, candidate n}; if none, {base, 3'd7}.
- inta: commit level L = vector[2:0] if int_rq, else spurious: no register changes. Commit clears IRR[L]; sets ISR[L] unless aeoi.
- Masked pending request keeps IRR; unmasking later raises int_rq.

## Timing
- Reset: IRR=ISR=0, IMR=8'hFF, base=0, sngl=ic4=aeoi=rsel=0, ir_d=0, state=READY, int_rq=0, vector=8'h00.
- ir rises seen at edge k: IRR set at k; int_rq/vector valid after edge k+1.
- inta at edge m: IRR/ISR updated at m; int_rq/vector reflect new state after edge m+1.
- Simultaneous new edge on IR L and inta committing L: IRR[L] stays 1 (new edge wins); ISR[L] set.
- Simultaneous EOI write and inta: EOI applied to pre-inta ISR, then inta sets its bit.
- ICW1 mid-operation discards all pending/in-service state; int_rq 0 until READY.
- EOI with ISR empty: no effect. Writes with cs=0 or in W_* state with a0=0 and din[4]=0: ignored.

## Test plan
- Reset -> int_rq=0, vector=8'h00; read a0=1 -> 8'hFF.
- ICW1=8'h13, ICW2=8'h20, ICW4=8'h01, OCW1=8'hFA; pulse ir[0] -> int_rq=1, vector=8'h20; inta -> ISR=8'h01, int_rq=0.
- With ISR[0] set, pulse ir[2] -> int_rq stays 0; EOI 8'h20 -> ISR=0, int_rq=1, vector=8'h22.
- Pulse ir[0] and ir[2] same cycle -> vector=8'h20 first; after inta + EOI 8'h20 -> vector=8'h22.
- ICW4=8'h03 (AEOI): ir[2] pulse, inta -> ISR stays 0, IRR[2]=0; OCW3=8'h0B read a0=0 -> 8'h00.
- IMR=8'hFF, pulse ir[0] -> int_rq=0, IRR read=8'h01; inta -> no change; IMR=8'hFE -> int_rq=1, vector=8'h20.
